// File: rtl/line_buffer_ctrl_if.sv
// Video timing inputs, their delayed copies and the shared line-RAM control lines.
// The master side is the video source; the slave side is line_buffer_ctrl.
interface line_buffer_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                  i_vid_hsync;
  logic                  i_vid_vsync;
  logic                  i_vid_VDE;
  logic                  o_vid_hsync;
  logic                  o_vid_vsync;
  logic                  o_vid_VDE;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_wea0;
  logic                  o_wea1;
  logic                  o_bank_sel;

  modport master (
    output i_vid_hsync, i_vid_vsync, i_vid_VDE,
    input  o_vid_hsync, o_vid_vsync, o_vid_VDE, o_addr, o_wea0, o_wea1, o_bank_sel
  );

  modport slave (
    input  i_vid_hsync, i_vid_vsync, i_vid_VDE,
    output o_vid_hsync, o_vid_vsync, o_vid_VDE, o_addr, o_wea0, o_wea1, o_bank_sel
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line-buffer controller for a 3x3 window: column addressing, bank write
// enables, line/frame bookkeeping and a matched delay line for the video timing.
module line_buffer_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  line_buffer_ctrl_if.slave     vid,
  output logic [10:0]           o_line_cnt,
  output logic [ADDR_WIDTH-1:0] o_line_width,
  output logic                  o_win_valid,
  output logic                  o_frame_start,
  output logic                  o_overflow
);
  typedef enum logic [1:0] {StIdle, StWaitLine, StActive, StBlank} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrTwo = ADDR_WIDTH'(2);
  localparam logic [10:0]           LineMax = 11'd2047;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] width_q, width_d;
  logic [10:0]           line_q, line_d;
  logic                  bank_q, bank_d;
  logic                  ovf_q, ovf_d;
  logic                  fs_q, fs_d;
  logic                  win_q, win_d;
  logic                  wea0_q, wea0_d;
  logic                  wea1_q, wea1_d;
  logic                  vs_q, vde_q, primed_q;
  logic                  vs_rise, vde_rise, wr_en;

  // primed_q masks edges on the first cycle after reset.
  assign vs_rise  = primed_q & vid.i_vid_vsync & ~vs_q;
  assign vde_rise = primed_q & vid.i_vid_VDE & ~vde_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    width_d = width_q;
    line_d  = line_q;
    bank_d  = bank_q;
    ovf_d   = ovf_q;
    fs_d    = 1'b0;
    if (vs_rise) begin
      // Frame restart wins over a coincident VDE rise, which then opens line 0.
      fs_d    = 1'b1;
      line_d  = '0;
      bank_d  = 1'b0;
      addr_d  = '0;
      state_d = (state_q != StIdle && vde_rise) ? StActive : StWaitLine;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWaitLine, StBlank: begin
          if (vde_rise) begin
            state_d = StActive;
            addr_d  = '0;
          end
        end
        StActive: begin
          if (!vid.i_vid_VDE) begin
            state_d = StBlank;
            width_d = (addr_q == AddrMax) ? AddrMax : addr_q + AddrOne;
            bank_d  = ~bank_q;
            line_d  = (line_q == LineMax) ? LineMax : line_q + 11'd1;
          end else if (addr_q == AddrMax) begin
            ovf_d = 1'b1;
          end else begin
            addr_d = addr_q + AddrOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    wr_en  = (state_d == StActive) && vid.i_vid_VDE;
    wea0_d = wr_en & ~bank_d;
    wea1_d = wr_en & bank_d;
    win_d  = wr_en && (line_d >= 11'd2) && (addr_d >= AddrTwo);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      width_q  <= '0;
      line_q   <= '0;
      bank_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fs_q     <= 1'b0;
      win_q    <= 1'b0;
      wea0_q   <= 1'b0;
      wea1_q   <= 1'b0;
      vs_q     <= 1'b0;
      vde_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      line_q   <= line_d;
      bank_q   <= bank_d;
      ovf_q    <= ovf_d;
      fs_q     <= fs_d;
      win_q    <= win_d;
      wea0_q   <= wea0_d;
      wea1_q   <= wea1_d;
      vs_q     <= vid.i_vid_vsync;
      vde_q    <= vid.i_vid_VDE;
      primed_q <= 1'b1;
    end
  end

  assign vid.o_addr     = addr_q;
  assign vid.o_wea0     = wea0_q;
  assign vid.o_wea1     = wea1_q;
  assign vid.o_bank_sel = bank_q;
  assign o_line_cnt     = line_q;
  assign o_line_width   = width_q;
  assign o_win_valid    = win_q;
  assign o_frame_start  = fs_q;
  assign o_overflow     = ovf_q;

  if (SYNC_DELAY == 0) begin : g_sync_pass
    assign vid.o_vid_hsync = vid.i_vid_hsync;
    assign vid.o_vid_vsync = vid.i_vid_vsync;
    assign vid.o_vid_VDE   = vid.i_vid_VDE;
  end else begin : g_sync_dly
    logic [2:0] sync_q [SYNC_DELAY];

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        for (int i = 0; i < SYNC_DELAY; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= {vid.i_vid_hsync, vid.i_vid_vsync, vid.i_vid_VDE};
        for (int i = 1; i < SYNC_DELAY; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign {vid.o_vid_hsync, vid.o_vid_vsync, vid.o_vid_VDE} = sync_q[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: a frame/line/pixel-count model checked every
// cycle, plus literal expectations at line and frame boundaries.
module tb_line_buffer_ctrl;
  localparam int AW   = 11;
  localparam int MAXA = 2047;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [10:0]   line_cnt;
  logic [AW-1:0] line_width;
  logic          win_valid, frame_start, overflow;

  line_buffer_ctrl_if #(.ADDR_WIDTH(AW)) vif ();

  line_buffer_ctrl #(.ADDR_WIDTH(AW), .SYNC_DELAY(2)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .vid          (vif),
    .o_line_cnt   (line_cnt),
    .o_line_width (line_width),
    .o_win_valid  (win_valid),
    .o_frame_start(frame_start),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks frame/line/pixel position from the stimulus alone.
  bit       m_ok, m_primed, m_vs_q, m_vde_q, m_framing, m_in_line, m_ovf, m_fs;
  int       m_line, m_pix, m_width;
  logic [2:0] m_h1, m_h2;

  always @(posedge clk) begin
    bit hs, vs, vde, vs_r, vde_r, start;
    hs  = vif.i_vid_hsync;
    vs  = vif.i_vid_vsync;
    vde = vif.i_vid_VDE;
    if (!n_rst) begin
      m_primed = 0; m_vs_q = 0; m_vde_q = 0; m_framing = 0; m_in_line = 0;
      m_ovf = 0; m_fs = 0; m_line = 0; m_pix = 0; m_width = 0; m_h1 = '0; m_h2 = '0;
    end else begin
      vs_r  = m_primed && vs && !m_vs_q;
      vde_r = m_primed && vde && !m_vde_q;
      m_fs  = vs_r;
      if (vs_r) begin
        start     = m_framing && vde_r;
        m_framing = 1;
        m_line    = 0;
        m_in_line = start;
        m_pix     = 0;
      end else if (m_in_line) begin
        if (!vde) begin
          m_in_line = 0;
          m_width   = (m_pix + 1 > MAXA) ? MAXA : m_pix + 1;
          if (m_line < 2047) m_line++;
        end else begin
          m_pix++;
          if (m_pix > MAXA) m_ovf = 1;
        end
      end else if (m_framing && vde_r) begin
        m_in_line = 1;
        m_pix     = 0;
      end
      m_primed = 1; m_vs_q = vs; m_vde_q = vde;
      m_h2 = m_h1;
      m_h1 = {hs, vs, vde};
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    int ea;
    if (m_ok) begin
      ea = (m_pix > MAXA) ? MAXA : m_pix;
      chk("line_cnt", line_cnt, m_line);
      chk("bank_sel", vif.o_bank_sel, m_line % 2);
      chk("line_width", line_width, m_width);
      chk("overflow", overflow, m_ovf);
      chk("frame_start", frame_start, m_fs);
      chk("wea0", vif.o_wea0, m_in_line && (m_line % 2 == 0));
      chk("wea1", vif.o_wea1, m_in_line && (m_line % 2 == 1));
      chk("wea_exclusive", vif.o_wea0 & vif.o_wea1, 0);
      chk("win_valid", win_valid, m_in_line && m_line >= 2 && ea >= 2);
      if (m_in_line) chk("addr", vif.o_addr, ea);
      chk("vid_delay", {vif.o_vid_hsync, vif.o_vid_vsync, vif.o_vid_VDE}, m_h2);
    end
  end

  // Per-interval counters of observed output activity.
  int wr_cnt, win_cnt, fs_cnt;
  always @(posedge clk) begin
    if (vif.o_wea0 || vif.o_wea1) wr_cnt++;
    if (win_valid) win_cnt++;
    if (frame_start) fs_cnt++;
  end

  int  last_addr, first_lc, first_bank;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    fs_cnt = 0;
    vif.i_vid_vsync = 1'b1;
    tick(2);
    vif.i_vid_vsync = 1'b0;
    tick(2);
  endtask

  task automatic do_line(input int npix, input int nblank);
    wr_cnt = 0;
    win_cnt = 0;
    vif.i_vid_VDE = 1'b1;
    tick();
    first_lc   = line_cnt;
    first_bank = vif.o_bank_sel;
    tick(npix - 1);
    last_addr = vif.o_addr;
    vif.i_vid_VDE   = 1'b0;
    vif.i_vid_hsync = 1'b1;
    tick();
    vif.i_vid_hsync = 1'b0;
    tick(nblank - 1);
  endtask

  initial begin
    vif.i_vid_hsync = 1'b0;
    vif.i_vid_vsync = 1'b0;
    vif.i_vid_VDE   = 1'b0;
    n_rst = 1'b0;
    tick(3);
    chk("rst_addr", vif.o_addr, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_width", line_width, 0);
    chk("rst_overflow", overflow, 0);
    n_rst = 1'b1;
    tick(2);

    // VDE with no vsync yet: stays idle.
    wr_cnt = 0;
    vif.i_vid_VDE = 1'b1;
    tick(5);
    vif.i_vid_VDE = 1'b0;
    tick(3);
    chk("pre_vsync_writes", wr_cnt, 0);
    chk("pre_vsync_line_cnt", line_cnt, 0);

    vsync_pulse();
    chk("frame_start_pulses", fs_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      do_line(8, 4);
      chk("line_first_cnt", first_lc, i);
      chk("line_first_bank", first_bank, i % 2);
      chk("line_last_addr", last_addr, 7);
      chk("line_width_8", line_width, 8);
      chk("line_cnt_after", line_cnt, i + 1);
      chk("bank_after", vif.o_bank_sel, (i + 1) % 2);
      chk("writes_per_line", wr_cnt, 8);
      chk("win_cycles", win_cnt, (i >= 2) ? 6 : 0);
    end

    // Overlong line saturates the address and sets a sticky overflow.
    vsync_pulse();
    do_line(2050, 4);
    chk("ovf_addr_hold", last_addr, 2047);
    chk("ovf_flag", overflow, 1);
    chk("ovf_width", line_width, 2047);
    vsync_pulse();
    chk("ovf_sticky_new_frame", overflow, 1);
    do_line(3, 3);
    chk("short_width", line_width, 3);
    chk("ovf_still_set", overflow, 1);

    // Vsync and VDE rising together: restart, and that line is line 0.
    vif.i_vid_vsync = 1'b1;
    do_line(6, 3);
    vif.i_vid_vsync = 1'b0;
    tick(2);
    chk("coinc_first_cnt", first_lc, 0);
    chk("coinc_line_cnt", line_cnt, 1);
    chk("coinc_width", line_width, 6);
    chk("coinc_writes", wr_cnt, 6);

    // Reset at pixel 5 of line 2.
    vsync_pulse();
    do_line(8, 4);
    do_line(8, 4);
    vif.i_vid_VDE = 1'b1;
    tick(5);
    n_rst = 1'b0;
    tick(2);
    chk("midrst_addr", vif.o_addr, 0);
    chk("midrst_wea", vif.o_wea0 | vif.o_wea1, 0);
    chk("midrst_line_cnt", line_cnt, 0);
    chk("midrst_width", line_width, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_win", win_valid, 0);
    chk("midrst_vid_vde", vif.o_vid_VDE, 0);
    n_rst = 1'b1;
    wr_cnt = 0;
    tick(4);
    vif.i_vid_VDE = 1'b0;
    tick(3);
    chk("post_rst_writes", wr_cnt, 0);
    vsync_pulse();
    do_line(8, 4);
    chk("post_rst_first_cnt", first_lc, 0);
    chk("post_rst_first_bank", first_bank, 0);
    chk("post_rst_writes_line", wr_cnt, 8);
    chk("post_rst_width", line_width, 8);

    // Random timing pattern; model covers delay line and FSM.
    for (int i = 0; i < 200; i++) begin
      vif.i_vid_hsync = 1'($urandom % 2);
      vif.i_vid_vsync = ($urandom_range(0, 7) == 0);
      vif.i_vid_VDE   = 1'($urandom % 2);
      tick();
    end
    vif.i_vid_hsync = 1'b0;
    vif.i_vid_vsync = 1'b0;
    vif.i_vid_VDE   = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
